uart_tx_arb: RTL and testbench

Shares the single UART transmitter behind `uart_txd` between NREQ byte-stream requesters (e.g. Forth console output, debug/trace port). Grants are held per "line": a requester owns the transmitter until it sends LF (0x0A) or goes idle for TIMEOUT cycles, so text from different sources never interleaves mid-line. Sits between the requesters and the UART TX core inside `top`, with a one-entry registered output toward the TX core.

---
 rtl/uart_tx_arb.sv | 134 +++++++++++++
 tb/tb_uart_tx_arb.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: line-locked round-robin arbiter in front of a single UART TX core.
// A requester keeps the transmitter until it sends EOL or stays idle for TIMEOUT
// cycles. A one-entry registered output stage feeds the TX core.
module uart_tx_arb #(
   parameter int          NREQ    = 2,
   parameter int          TIMEOUT = 255,
   parameter logic [7:0]  EOL     = 8'h0A
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [8*NREQ-1:0]  req_data,
   output logic [NREQ-1:0]    req_ready,
   output logic               tx_valid,
   output logic [7:0]         tx_data,
   input  logic               tx_ready,
   output logic [NREQ-1:0]    grant,
   output logic               busy
);

   localparam int             LW       = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int             CW       = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]  TMO      = CW'(TIMEOUT);
   localparam logic [LW-1:0]  LAST_RST = LW'(NREQ - 1);

   typedef enum logic {S_IDLE, S_GRANT} state_e;

   state_e            state_q, state_d;
   logic [NREQ-1:0]   grant_q, grant_d;
   logic [LW-1:0]     last_q, last_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              tx_valid_q, tx_valid_d;
   logic [7:0]        tx_data_q, tx_data_d;

   logic              own_valid;
   logic [7:0]        own_data;
   logic              out_ready;
   logic              accept;
   logic              win_found;
   logic [LW-1:0]     win_idx;
   logic [LW-1:0]     cand;

   // Owner's valid/data selected through the one-hot grant; handshake qualifier.
   always_comb begin
      own_data = 8'h00;
      for (int i = 0; i < NREQ; i++) begin
         own_data = own_data | ({8{grant_q[i]}} & req_data[8*i +: 8]);
      end
      own_valid = |(req_valid & grant_q);
      out_ready = !tx_valid_q || tx_ready;
      accept    = (state_q == S_GRANT) && own_valid && out_ready;
      req_ready = ((state_q == S_GRANT) && out_ready) ? grant_q : '0;
   end

   // Round-robin search starting one past the last winner.
   always_comb begin
      win_found = 1'b0;
      win_idx   = last_q;
      cand      = last_q;
      for (int k = 1; k <= NREQ; k++) begin
         cand = LW'((int'(last_q) + k) % NREQ);
         if (!win_found && req_valid[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   // Next-state: arbitration, idle counter, release and the output register.
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      last_d     = last_q;
      cnt_d      = cnt_q;
      tx_valid_d = tx_valid_q && !tx_ready;
      tx_data_d  = tx_data_q;

      if (accept) begin
         tx_valid_d = 1'b1;
         tx_data_d  = own_data;
      end

      case (state_q)
         S_IDLE: begin
            if (win_found) begin
               state_d          = S_GRANT;
               grant_d          = '0;
               grant_d[win_idx] = 1'b1;
               last_d           = win_idx;
               cnt_d            = '0;
            end
         end
         S_GRANT: begin
            // A stalled-but-valid owner is not idle, so only a missing valid counts.
            if (accept || own_valid) cnt_d = '0;
            else if (cnt_q != TMO)   cnt_d = cnt_q + CW'(1);
            if ((accept && own_data == EOL) || cnt_d == TMO) begin
               state_d = S_IDLE;
               grant_d = '0;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
            grant_d = '0;
         end
      endcase
   end

   // State and output registers; reset discards any pending output byte.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         grant_q    <= '0;
         last_q     <= LAST_RST;
         cnt_q      <= '0;
         tx_valid_q <= 1'b0;
         tx_data_q  <= 8'h00;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         last_q     <= last_d;
         cnt_q      <= cnt_d;
         tx_valid_q <= tx_valid_d;
         tx_data_q  <= tx_data_d;
      end
   end

   assign tx_valid = tx_valid_q;
   assign tx_data  = tx_data_q;
   assign grant    = grant_q;
   assign busy     = (state_q == S_GRANT) || tx_valid_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: three byte-queue sources, a TX sink log and a grant log.
module tb_uart_tx_arb;

   logic        clk;
   logic        rst_n;
   logic [2:0]  req_valid = 3'b000;
   logic [23:0] req_data  = 24'h0;
   logic [2:0]  req_ready;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready;
   logic [2:0]  grant;
   logic        busy;

   uart_tx_arb #(.NREQ(3), .TIMEOUT(4), .EOL(8'h0A)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .grant(grant), .busy(busy)
   );

   int          checks = 0;
   int          fails  = 0;
   int          cyc    = 0;
   logic [2:0]  gate   = 3'b000;
   logic [2:0]  hs     = 3'b000;
   logic [7:0]  q [3][$];
   logic [7:0]  txlog [$];
   int          txcyc [$];
   logic [2:0]  glog [$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Sources: pop a byte after each handshake, present the queue head while gated on.
   always @(posedge clk) begin
      #1;
      for (int i = 0; i < 3; i++) begin
         if (hs[i] && q[i].size() > 0) void'(q[i].pop_front());
         if (gate[i] && q[i].size() > 0) begin
            req_valid[i]       = 1'b1;
            req_data[8*i +: 8] = q[i][0];
         end else begin
            req_valid[i]       = 1'b0;
            req_data[8*i +: 8] = 8'h00;
         end
      end
   end

   // Mid-cycle monitor: handshakes about to complete, TX bytes and owners.
   always @(negedge clk) begin
      hs <= req_valid & req_ready;
      if (tx_valid && tx_ready) begin
         txlog.push_back(tx_data);
         txcyc.push_back(cyc);
      end
      if (grant != 3'b000) glog.push_back(grant);
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic settle();
      gate     = 3'b000;
      tx_ready = 1'b1;
      tick();
      tick();
      for (int k = 0; k < 40 && busy !== 1'b0; k++) tick();
      checks++;
      if (busy !== 1'b0) begin
         fails++;
         $display("FAIL settle_idle: busy=%b want 0", busy);
      end
      for (int i = 0; i < 3; i++) q[i].delete();
      tick();
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      tx_ready = 1'b1;
      q[0]     = {8'h0A};
      q[1]     = {8'h0A};
      gate     = 3'b011;
      tick();
      tick();
      checks++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL rst_tx_valid: got %b want 0", tx_valid); end
      checks++; if (tx_data !== 8'h00) begin fails++; $display("FAIL rst_tx_data: got %h want 00", tx_data); end
      checks++; if (grant !== 3'b000) begin fails++; $display("FAIL rst_grant: got %b want 000", grant); end
      checks++; if (req_ready !== 3'b000) begin fails++; $display("FAIL rst_req_ready: got %b want 000", req_ready); end
      checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", busy); end
      rst_n = 1'b1;
      #1;
      checks++; if (grant !== 3'b000) begin fails++; $display("FAIL rst_rel_grant: got %b want 000", grant); end
      tick();
      checks++; if (grant !== 3'b001) begin fails++; $display("FAIL first_grant: got %b want 001", grant); end
      checks++; if (req_ready !== 3'b001) begin fails++; $display("FAIL first_ready: got %b want 001", req_ready); end
      tick();
      checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h0A) begin fails++; $display("FAIL first_byte: got %b/%h want 1/0a", tx_valid, tx_data); end
      checks++; if (grant !== 3'b000) begin fails++; $display("FAIL eol_release: got %b want 000", grant); end
      tick();
      checks++; if (grant !== 3'b010) begin fails++; $display("FAIL second_grant: got %b want 010", grant); end
      checks++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL drain: got %b want 0", tx_valid); end
      tick();
      checks++; if (tx_valid !== 1'b1 || grant !== 3'b000) begin fails++; $display("FAIL second_byte: got %b/%b want 1/000", tx_valid, grant); end
      settle();
   endtask

   task automatic test_line_lock();
      logic [7:0] exp_b [6];
      int         exp_g [5];
      exp_b = '{8'h41, 8'h42, 8'h0A, 8'h78, 8'h79, 8'h0A};
      exp_g = '{1, 1, 2, 1, 1};
      txlog.delete();
      txcyc.delete();
      q[0] = {8'h41, 8'h42, 8'h0A};
      q[1] = {8'h78, 8'h79, 8'h0A};
      gate = 3'b011;
      for (int k = 0; k < 40 && txlog.size() < 6; k++) tick();
      checks++;
      if (txlog.size() != 6) begin
         fails++;
         $display("FAIL ll_count: got %0d bytes want 6", txlog.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            checks++;
            if (txlog[i] !== exp_b[i]) begin fails++; $display("FAIL ll_byte%0d: got %h want %h", i, txlog[i], exp_b[i]); end
         end
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (txcyc[i+1] - txcyc[i] != exp_g[i]) begin fails++; $display("FAIL ll_gap%0d: got %0d want %0d", i, txcyc[i+1] - txcyc[i], exp_g[i]); end
         end
      end
      settle();
   endtask

   task automatic test_backpressure();
      logic [7:0] exp_b [5];
      exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h0A};
      txlog.delete();
      q[0]     = {8'h11, 8'h22, 8'h33, 8'h44, 8'h0A};
      tx_ready = 1'b0;
      gate     = 3'b001;
      for (int k = 0; k < 10 && grant !== 3'b001; k++) tick();
      checks++; if (grant !== 3'b001) begin fails++; $display("FAIL bp_grant: got %b want 001", grant); end
      tick();
      for (int k = 0; k < 10; k++) begin
         checks++;
         if (tx_valid !== 1'b1 || tx_data !== 8'h11) begin fails++; $display("FAIL bp_hold%0d: got %b/%h want 1/11", k, tx_valid, tx_data); end
         checks++;
         if (req_ready[0] !== 1'b0 || grant !== 3'b001) begin fails++; $display("FAIL bp_stall%0d: ready=%b grant=%b want 0/001", k, req_ready[0], grant); end
         tick();
      end
      tx_ready = 1'b1;
      for (int k = 0; k < 30 && txlog.size() < 5; k++) tick();
      checks++;
      if (txlog.size() != 5) begin
         fails++;
         $display("FAIL bp_count: got %0d bytes want 5", txlog.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (txlog[i] !== exp_b[i]) begin fails++; $display("FAIL bp_byte%0d: got %h want %h", i, txlog[i], exp_b[i]); end
         end
      end
      settle();
   endtask

   task automatic test_timeout();
      logic [2:0] exp_gr [5];
      exp_gr = '{3'b001, 3'b001, 3'b001, 3'b000, 3'b010};
      q[0] = {8'h41};
      q[1] = {8'h0A};
      gate = 3'b001;
      for (int k = 0; k < 10 && grant !== 3'b001; k++) tick();
      checks++; if (grant !== 3'b001) begin fails++; $display("FAIL to_grant: got %b want 001", grant); end
      gate = 3'b011;
      tick();
      checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin fails++; $display("FAIL to_byte: got %b/%h want 1/41", tx_valid, tx_data); end
      for (int k = 0; k < 5; k++) begin
         tick();
         checks++;
         if (grant !== exp_gr[k]) begin fails++; $display("FAIL to_idle%0d: got %b want %b", k + 1, grant, exp_gr[k]); end
         if (k == 3) begin
            checks++;
            if (busy !== 1'b0) begin fails++; $display("FAIL to_busy: got %b want 0", busy); end
         end
      end
      settle();
   endtask

   task automatic test_reset_mid();
      q[1]     = {8'h31, 8'h32, 8'h33};
      tx_ready = 1'b0;
      gate     = 3'b010;
      for (int k = 0; k < 10 && grant !== 3'b010; k++) tick();
      checks++; if (grant !== 3'b010) begin fails++; $display("FAIL rm_grant: got %b want 010", grant); end
      tick();
      checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h31) begin fails++; $display("FAIL rm_byte: got %b/%h want 1/31", tx_valid, tx_data); end
      #1 rst_n = 1'b0;
      #1;
      checks++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin fails++; $display("FAIL rm_tx_drop: got %b/%h want 0/00", tx_valid, tx_data); end
      checks++; if (grant !== 3'b000 || busy !== 1'b0) begin fails++; $display("FAIL rm_grant_drop: got %b/%b want 000/0", grant, busy); end
      q[0]     = {8'h0A};
      gate     = 3'b011;
      tx_ready = 1'b1;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      checks++; if (grant !== 3'b001) begin fails++; $display("FAIL rm_rearb: got %b want 001", grant); end
      settle();
   endtask

   task automatic test_fairness();
      logic [2:0] exp_gr [6];
      exp_gr = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      glog.delete();
      for (int i = 0; i < 3; i++) q[i] = {8'h0A, 8'h0A};
      gate = 3'b111;
      for (int k = 0; k < 40 && glog.size() < 6; k++) tick();
      checks++;
      if (glog.size() < 6) begin
         fails++;
         $display("FAIL fair_count: got %0d grants want 6", glog.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            checks++;
            if (glog[i] !== exp_gr[i]) begin fails++; $display("FAIL fair_line%0d: got %b want %b", i, glog[i], exp_gr[i]); end
         end
      end
      settle();
   endtask

   initial begin
      rst_n    = 1'b0;
      tx_ready = 1'b1;
      test_reset();
      test_line_lock();
      test_backpressure();
      test_timeout();
      test_reset_mid();
      test_fairness();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
